// File: rtl/mux4_scanner_pkg.sv
// Shared types and constants for the 4-channel mux scanner.
package mux4_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  typedef logic [NUM_CH-1:0] frame_t;
endpackage

// File: rtl/mux4_scanner_if.sv
// Downstream frame channel of the scanner.
// Handshake: a frame transfers on any rising edge where frame_valid & frame_ready;
// once raised, frame_valid and frame stay stable until that transfer happens.
interface mux4_scanner_if;
  import mux4_scan_pkg::*;

  frame_t frame;
  logic   frame_valid;
  logic   frame_ready;

  modport master (output frame, output frame_valid, input frame_ready);
  modport slave  (input frame, input frame_valid, output frame_ready);
endinterface

// File: rtl/mux4.sv
// Plain 4->1 single-bit multiplexer scanned by mux4_scanner.
module mux4 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] sel,
  output logic       z
);
  always_comb begin
    z = d0;
    case (sel)
      2'd0: z = d0;
      2'd1: z = d1;
      2'd2: z = d2;
      2'd3: z = d3;
      default: z = d0;
    endcase
  end
endmodule

// File: rtl/mux4_scanner_settle_timer.sv
// Settle timer: tick pulses on the last of every SETTLE_CYCLES enabled cycles.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  logic [3:0] cnt;

  assign tick = enable && (cnt == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/mux4_scanner.sv
// Steps sel through the mux channels, samples z_in after each settle period,
// and hands completed 4-bit frames downstream through a one-frame buffer.
module mux4_scanner
  import mux4_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               continuous,
  input  logic               z_in,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               overrun,
  output scan_state_t        state,
  mux4_scanner_if.master     frame_bus
);
  scan_state_t      state_d;
  logic [SEL_W-1:0] sel_d;
  frame_t           shreg, shreg_d, assembled;
  frame_t           frame_r, frame_d;
  logic             valid_r, valid_d;
  logic             overrun_d;
  logic             tick;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == IDLE),
    .enable (state == SCAN),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state;
    sel_d     = sel;
    shreg_d   = shreg;
    frame_d   = frame_r;
    valid_d   = valid_r;
    overrun_d = overrun;
    assembled = shreg;
    assembled[sel] = z_in;

    if (valid_r && frame_bus.frame_ready) valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          sel_d     = '0;
          shreg_d   = '0;
          overrun_d = 1'b0;
        end
      end
      SCAN: begin
        if (tick) begin
          shreg_d = assembled;
          sel_d   = sel + 1'b1;
          if (sel == SEL_W'(NUM_CH - 1)) begin
            shreg_d = '0;
            sel_d   = '0;
            // A buffer being drained on this same edge counts as free.
            if (!valid_r || frame_bus.frame_ready) begin
              frame_d = assembled;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            if (!continuous) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      shreg   <= '0;
      frame_r <= '0;
      valid_r <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      sel     <= sel_d;
      shreg   <= shreg_d;
      frame_r <= frame_d;
      valid_r <= valid_d;
      overrun <= overrun_d;
    end
  end

  assign busy                  = (state != IDLE);
  assign frame_bus.frame       = frame_r;
  assign frame_bus.frame_valid = valid_r;
endmodule

// File: tb/tb_mux4_scanner.sv
// Bench for mux4_scanner driving a real mux4, with a frame scoreboard.
module tb_mux4_scanner;
  import mux4_scan_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, start1 = 1'b0, continuous = 1'b0;
  logic d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic [1:0] sel, sel1;
  logic z, z1, busy, busy1, overrun, overrun1;
  scan_state_t state, state1;

  mux4_scanner_if if0 ();
  mux4_scanner_if if1 ();

  mux4 u_mux0 (.d0(d0), .d1(d1), .d2(d2), .d3(d3), .sel(sel), .z(z));
  mux4 u_mux1 (.d0(d0), .d1(d1), .d2(d2), .d3(d3), .sel(sel1), .z(z1));

  mux4_scanner #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .z_in(z),
    .sel(sel), .busy(busy), .overrun(overrun), .state(state), .frame_bus(if0)
  );

  mux4_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .continuous(continuous), .z_in(z1),
    .sel(sel1), .busy(busy1), .overrun(overrun1), .state(state1), .frame_bus(if1)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] exp_q[$];

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  task automatic wait_rel(input int e0, input int n);
    while (cyc - e0 < n) @(negedge clk);
  endtask

  task automatic start_scan(output int e0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    e0 = cyc;
  endtask

  // Waits (at negedges) for a transfer on if0 and steps past its edge.
  task automatic collect(input int budget, output frame_t got, output int at, output bit ok);
    ok = 1'b0; got = '0; at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (if0.frame_valid && if0.frame_ready) begin
        got = if0.frame; at = cyc; ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", sel); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
    tests++; if (if0.frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", if0.frame_valid); end
    tests++; if (if0.frame !== 4'd0) begin fails++; $display("FAIL reset_frame got %b want 0000", if0.frame); end
    tests++; if (state !== IDLE) begin fails++; $display("FAIL reset_state got %0d want IDLE", state); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_scan;
    int e0, at; frame_t got; bit ok; logic [3:0] exp;
    continuous = 1'b0; if0.frame_ready = 1'b1;
    set_d(4'b1010); exp_q.push_back(4'b1010);
    start_scan(e0);
    collect(40, got, at, ok);
    exp = exp_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL single_timeout got none want frame"); end
    tests++; if (got !== exp) begin fails++; $display("FAIL single_frame got %b want %b", got, exp); end
    tests++; if (at - e0 !== 8) begin fails++; $display("FAIL single_latency got %0d want 8", at - e0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", busy); end
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL single_sel got %0d want 0", sel); end
    tests++; if (if0.frame_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b want 0", if0.frame_valid); end
  endtask

  task automatic test_continuous;
    int e0, at; frame_t got; bit ok;
    logic [3:0] old_v, new_v, exp;
    old_v = 4'b0011; new_v = 4'b1100;
    continuous = 1'b1; if0.frame_ready = 1'b1;
    set_d(old_v);
    // Channel k of frame n samples at edge 8n+2(k+1); d changes after edge 11.
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 4; k++)
        exp[k] = (8 * n + 2 * (k + 1) <= 11) ? old_v[k] : new_v[k];
      exp_q.push_back(exp);
    end
    start_scan(e0);
    for (int n = 0; n < 4; n++) begin
      if (n == 1) begin wait_rel(e0, 11); set_d(new_v); end
      if (n == 3) continuous = 1'b0;
      collect(40, got, at, ok);
      exp = exp_q.pop_front();
      tests++; if (!ok || got !== exp) begin fails++; $display("FAIL cont_frame%0d got %b want %b", n, got, exp); end
      tests++; if (at - e0 !== 8 * (n + 1)) begin fails++; $display("FAIL cont_time%0d got %0d want %0d", n, at - e0, 8 * (n + 1)); end
    end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL cont_overrun got %b want 0", overrun); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_end_busy got %b want 0", busy); end
  endtask

  task automatic test_overrun;
    int e0, at; frame_t got; bit ok; logic [3:0] exp;
    continuous = 1'b1; if0.frame_ready = 1'b0;
    set_d(4'b1001); exp_q.push_back(4'b1001);
    start_scan(e0);
    wait_rel(e0, 8);
    tests++; if (if0.frame_valid !== 1'b1 || if0.frame !== 4'b1001) begin fails++; $display("FAIL ovr_first got %b/%b want 1/1001", if0.frame_valid, if0.frame); end
    wait_rel(e0, 9); set_d(4'b0110);
    wait_rel(e0, 15);
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_early got %b want 0", overrun); end
    wait_rel(e0, 16);
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b want 1", overrun); end
    tests++; if (if0.frame !== 4'b1001 || if0.frame_valid !== 1'b1) begin fails++; $display("FAIL ovr_held got %b/%b want 1001/1", if0.frame, if0.frame_valid); end
    continuous = 1'b0;
    wait_rel(e0, 25);
    tests++; if (busy !== 1'b0 || overrun !== 1'b1) begin fails++; $display("FAIL ovr_idle got busy %b ovr %b want 0 1", busy, overrun); end
    if0.frame_ready = 1'b1;
    collect(10, got, at, ok);
    exp = exp_q.pop_front();
    tests++; if (!ok || got !== exp) begin fails++; $display("FAIL ovr_drain got %b want %b", got, exp); end
    exp_q.push_back(4'b0110);
    start_scan(e0);
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", overrun); end
    collect(40, got, at, ok);
    exp = exp_q.pop_front();
    tests++; if (!ok || got !== exp || at - e0 !== 8) begin fails++; $display("FAIL ovr_rescan got %b at %0d want %b at 8", got, at - e0, exp); end
  endtask

  task automatic test_back_to_back;
    int e0, at; frame_t got; bit ok; logic [3:0] exp;
    continuous = 1'b1; if0.frame_ready = 1'b0;
    set_d(4'b0110); exp_q.push_back(4'b0110);
    start_scan(e0);
    wait_rel(e0, 9); set_d(4'b1101); exp_q.push_back(4'b1101);
    wait_rel(e0, 15); if0.frame_ready = 1'b1; continuous = 1'b0;
    collect(4, got, at, ok);
    exp = exp_q.pop_front();
    tests++; if (!ok || got !== exp || at - e0 !== 15) begin fails++; $display("FAIL b2b_first got %b at %0d want %b at 15", got, at - e0, exp); end
    tests++; if (if0.frame_valid !== 1'b1 || overrun !== 1'b0) begin fails++; $display("FAIL b2b_keep got valid %b ovr %b want 1 0", if0.frame_valid, overrun); end
    collect(4, got, at, ok);
    exp = exp_q.pop_front();
    tests++; if (!ok || got !== exp || at - e0 !== 16) begin fails++; $display("FAIL b2b_second got %b at %0d want %b at 16", got, at - e0, exp); end
    tests++; if (if0.frame_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_end got valid %b busy %b want 0 0", if0.frame_valid, busy); end
  endtask

  task automatic test_start_ignored;
    int e0, at; frame_t got; bit ok; logic [3:0] exp;
    continuous = 1'b0; if0.frame_ready = 1'b1;
    set_d(4'b0101); exp_q.push_back(4'b0101);
    start_scan(e0);
    wait_rel(e0, 3); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_rel(e0, 5); start = 1'b1; @(negedge clk); start = 1'b0;
    tests++; if (sel !== 2'd3) begin fails++; $display("FAIL ign_sel got %0d want 3", sel); end
    collect(40, got, at, ok);
    exp = exp_q.pop_front();
    tests++; if (!ok || got !== exp || at - e0 !== 8) begin fails++; $display("FAIL ign_frame got %b at %0d want %b at 8", got, at - e0, exp); end
  endtask

  task automatic test_settle_one;
    int e0, at; frame_t got; bit ok; logic [3:0] exp;
    set_d(4'b1110); exp_q.push_back(4'b1110);
    continuous = 1'b0; if1.frame_ready = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    e0 = cyc; ok = 1'b0; got = '0; at = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (if1.frame_valid) begin got = if1.frame; at = cyc; ok = 1'b1; end
      else @(negedge clk);
    end
    exp = exp_q.pop_front();
    tests++; if (!ok || got !== exp) begin fails++; $display("FAIL s1_frame got %b want %b", got, exp); end
    tests++; if (at - e0 !== 4) begin fails++; $display("FAIL s1_latency got %0d want 4", at - e0); end
  endtask

  task automatic test_reset_midscan;
    int e0, at; frame_t got; bit ok; logic [3:0] exp;
    continuous = 1'b1; if0.frame_ready = 1'b0;
    set_d(4'b1011);
    start_scan(e0);
    wait_rel(e0, 21);
    tests++; if (busy !== 1'b1 || sel !== 2'd2 || overrun !== 1'b1) begin fails++; $display("FAIL rst_pre got busy %b sel %0d ovr %b want 1 2 1", busy, sel, overrun); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (sel !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL rst_async_ctl got sel %0d busy %b want 0 0", sel, busy); end
    tests++; if (if0.frame !== 4'd0 || if0.frame_valid !== 1'b0) begin fails++; $display("FAIL rst_async_out got %b/%b want 0000/0", if0.frame, if0.frame_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_async_ovr got %b want 0", overrun); end
    @(negedge clk); rst_n = 1'b1;
    continuous = 1'b0; if0.frame_ready = 1'b1;
    set_d(4'b0111); exp_q.push_back(4'b0111);
    start_scan(e0);
    collect(40, got, at, ok);
    exp = exp_q.pop_front();
    tests++; if (!ok || got !== exp || at - e0 !== 8) begin fails++; $display("FAIL rst_rescan got %b at %0d want %b at 8", got, at - e0, exp); end
  endtask

  initial begin
    if0.frame_ready = 1'b1;
    if1.frame_ready = 1'b1;
    test_reset();
    test_single_scan();
    test_continuous();
    test_overrun();
    test_back_to_back();
    test_start_ignored();
    test_settle_one();
    test_reset_midscan();
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux4_scanner.md
# mux4_scanner

Sequential channel scanner that drives the select input of a 4->1 multiplexer and consumes its single-bit output. It steps `sel` through channels 0..3, waits a programmable settle time on each, samples the mux output, and assembles a 4-bit frame. Frames go downstream over a valid/ready handshake with a one-frame output buffer. It sits beside `mux4`: upstream of its `sel`, downstream of its `z`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2, number of cycles each channel is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a scan; accepted only in IDLE.
- `continuous`  in  1  1 = rescan back-to-back; sampled at each frame-completion edge.
- `z_in`  in  1  mux output being scanned.
- `sel`  out  2  channel select driven to the mux.
- `frame`  out  4  bit i = `z_in` sampled while `sel == i`.
- `frame_valid`  out  1  `frame` holds an unconsumed frame.
- `frame_ready`  in  1  downstream accepts `frame` when `frame_valid & frame_ready`.
- `busy`  out  1  scan in progress (state != IDLE).
- `overrun`  out  1  sticky; a completed frame was dropped.

## Operation
- Reset values: `sel` = 0, `frame` = 0, `frame_valid` = 0, `busy` = 0, `overrun` = 0, state IDLE, settle counter = 0, channel = 0.
- States: IDLE and SCAN.
- IDLE -> SCAN on `start`. On that edge: `sel` = 0, counter = 0, shift register = 0, `overrun` cleared.
- SCAN behaviour:
  - Counter increments each cycle.
  - When counter reaches `SETTLE_CYCLES-1`, `z_in` is captured into bit `sel` of the internal frame register on that edge. Counter resets and `sel` increments.
  - Capture on `sel` == 3 is the completion edge.
- Completion edge:
  - If the buffer is empty, or is being consumed on this same edge (`frame_valid & frame_ready`), the assembled frame is loaded into `frame` and `frame_valid` = 1.
  - Otherwise the new frame is discarded, `frame` is unchanged, and `overrun` = 1.
  - If `continuous` = 1, `sel` wraps to 0 and the next scan starts immediately.
  - If `continuous` = 0, go to IDLE with `sel` = 0.
- `frame_valid` falls on a handshake edge unless a new frame loads on the same edge.
- `start` while in SCAN is ignored. `continuous` changing mid-frame affects only the decision at the next completion edge.
- `overrun` is cleared only by reset or by an accepted `start`.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronously); the partial frame is lost.

## Timing
- Let E0 be the edge that accepts `start`. `sel` = 0 is valid after E0.
- Channel k is sampled at edge E0 + (k+1)·`SETTLE_CYCLES`.
- `frame_valid` rises after edge E0 + 4·`SETTLE_CYCLES` (8 cycles at the default).
- Continuous mode: one frame every 4·`SETTLE_CYCLES` cycles, with no dead cycles.
- `sel` and all other outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mux4_scan_pkg`:
  - constant `NUM_CH` = 4;
  - `SEL_W` = 2;
  - state enum `scan_state_t` {IDLE, SCAN};
  - frame type `frame_t` (logic [NUM_CH-1:0]).
- One sub-module, `settle_timer`:
  - parameterised by `SETTLE_CYCLES`;
  - inputs `clk`, `rst_n`, `clear`, `enable`;
  - output `tick`, a one-cycle pulse every `SETTLE_CYCLES` enabled cycles.
- Bench instantiates the real `mux4` between `sel` and `z_in`.

## Test plan
- Single scan, mux data d0..d3 = 0,1,0,1, `SETTLE_CYCLES` = 2, `frame_ready` = 1: `frame` = 4'b1010, `frame_valid` rises 8 cycles after `start`, then `busy` = 0 and `sel` = 0.
- Continuous with `frame_ready` held 1, d = 1,1,0,0 then changed to 0,0,1,1 mid-run: a frame every 8 cycles, 4'b0011 then 4'b1100. The frame spanning the change holds mixed bits per capture edge. `overrun` stays 0.
- Continuous with `frame_ready` = 0: first frame held, second completion sets `overrun` = 1, `frame` unchanged. A subsequent `start` (after `continuous` = 0 and return to IDLE) clears `overrun`.
- Handshake on the completion edge (`frame_valid` = 1, `frame_ready` = 1, new frame completing): new frame loads, `frame_valid` stays 1, `overrun` = 0.
- `start` pulsed during SCAN: no restart, frame timing unchanged. `SETTLE_CYCLES` = 1 gives a frame 4 cycles after `start`.
- `rst_n` asserted at cycle 5 of a scan: all outputs return to reset values asynchronously, before the next edge. After release, `start` produces a correct full frame.
